// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage memory access unit: opcodes,
// exception bit positions, FSM states and the access-size decode.
package mem_access_unit_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam int unsigned EXC_ADEL = 4;
    localparam int unsigned EXC_ADES = 5;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StDone,
        StCancel
    } mau_state_e;

    // Access size encoded as on the data bus (0 byte, 1 half, 2 word).
    function automatic logic [1:0] op_size(input logic [5:0] op);
        logic [1:0] size;
        case (op)
            OP_LB, OP_LBU, OP_SB: size = SIZE_BYTE;
            OP_LH, OP_LHU, OP_SH: size = SIZE_HALF;
            default:              size = SIZE_WORD;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// SRAM-like data bus: the unit is the master, memory is the slave.
interface mem_access_unit_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_access_unit_load_ext.sv
// Load result formatting: picks the addressed byte/half and sign- or
// zero-extends it according to the load opcode.
module mem_access_unit_load_ext
    import mem_access_unit_pkg::*;
(
    input  logic [5:0]  op_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Little-endian lane select followed by extension.
    always_comb begin
        byte_sel = rdata_i[{addr_i, 3'b000} +: 8];
        half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (op_i)
            OP_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  data_o = {24'h0, byte_sel};
            OP_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  data_o = {16'h0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage memory access unit: issues SRAM-like bus requests for loads and
// stores, stalls the pipeline until the data phase completes, and handles
// flushes that arrive while a transaction is outstanding.
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               stall_i,
    input  logic               memen_i,
    input  logic               rmem_i,
    input  logic               wmem_i,
    input  logic [5:0]         op_i,
    input  logic [31:0]        aluout_i,
    input  logic [31:0]        rdata2_i,
    input  logic [7:0]         except_i,
    mem_access_unit_if.master  bus,
    output logic [31:0]        rdata_o,
    output logic               stall_o,
    output logic [7:0]         except_o
);

    mau_state_e  state_q;
    logic [31:0] rdata_q;
    logic [1:0]  size;
    logic        misaligned;
    logic        start;
    logic [31:0] ext_data;

    assign size       = op_size(op_i);
    assign misaligned = ((size == SIZE_HALF) && aluout_i[0]) ||
                        ((size == SIZE_WORD) && (aluout_i[1:0] != 2'b00));
    // Reset term keeps the request and stall low while reset is held.
    assign start      = rst_ni && memen_i && !flush_i && !misaligned &&
                        (except_i == 8'h00) && (state_q == StIdle);

    mem_access_unit_load_ext u_load_ext (
        .op_i    (op_i),
        .addr_i  (aluout_i[1:0]),
        .rdata_i (bus.data_rdata),
        .data_o  (ext_data)
    );

    // Merge address-error bits into the incoming exception vector.
    always_comb begin
        except_o = except_i;
        if (memen_i && misaligned) begin
            if (rmem_i) except_o[EXC_ADEL] = 1'b1;
            if (wmem_i) except_o[EXC_ADES] = 1'b1;
        end
    end

    // Request fields come straight from the stable MEM-stage inputs.
    always_comb begin
        bus.data_req  = start || ((state_q == StReq) && !flush_i);
        bus.data_wr   = wmem_i;
        bus.data_size = size;
        bus.data_addr = aluout_i;
        case (size)
            SIZE_BYTE: begin
                bus.data_wdata = {4{rdata2_i[7:0]}};
                bus.data_wstrb = 4'b0001 << aluout_i[1:0];
            end
            SIZE_HALF: begin
                bus.data_wdata = {2{rdata2_i[15:0]}};
                bus.data_wstrb = 4'b0011 << {aluout_i[1], 1'b0};
            end
            default: begin
                bus.data_wdata = rdata2_i;
                bus.data_wstrb = 4'b1111;
            end
        endcase
        if (!wmem_i) bus.data_wstrb = 4'b0000;
    end

    // Stall and load-result outputs decoded from the current state.
    always_comb begin
        stall_o = start ||
                  (state_q == StReq) ||
                  ((state_q == StWait) && !bus.data_data_ok) ||
                  ((state_q == StCancel) && memen_i);
        rdata_o = 32'h0;
        if ((state_q == StWait) && bus.data_data_ok) rdata_o = ext_data;
        else if (state_q == StDone)                  rdata_o = rdata_q;
    end

    // Transaction FSM; captures the load result when the pipeline is held.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            rdata_q <= 32'h0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) state_q <= bus.data_addr_ok ? StWait : StReq;
                end
                StReq: begin
                    if (flush_i)               state_q <= StIdle;
                    else if (bus.data_addr_ok) state_q <= StWait;
                end
                StWait: begin
                    if (bus.data_data_ok) begin
                        if (stall_i) begin
                            state_q <= StDone;
                            rdata_q <= ext_data;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else if (flush_i) begin
                        // Response still owed by the bus; must be swallowed.
                        state_q <= StCancel;
                    end
                end
                StDone: begin
                    if (!stall_i || flush_i) state_q <= StIdle;
                end
                StCancel: begin
                    if (bus.data_data_ok) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit; the bus slave is driven by hand.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk;
    logic        rst_ni;
    logic        flush_i, stall_i, memen_i, rmem_i, wmem_i;
    logic [5:0]  op_i;
    logic [31:0] aluout_i, rdata2_i;
    logic [7:0]  except_i;
    logic [31:0] rdata_o;
    logic        stall_o;
    logic [7:0]  except_o;
    int          checks;
    int          errors;
    int          stall_cnt;

    mem_access_unit_if bus();

    mem_access_unit dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .flush_i  (flush_i),
        .stall_i  (stall_i),
        .memen_i  (memen_i),
        .rmem_i   (rmem_i),
        .wmem_i   (wmem_i),
        .op_i     (op_i),
        .aluout_i (aluout_i),
        .rdata2_i (rdata2_i),
        .except_i (except_i),
        .bus      (bus),
        .rdata_o  (rdata_o),
        .stall_o  (stall_o),
        .except_o (except_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        flush_i = 0; stall_i = 0; memen_i = 0; rmem_i = 0; wmem_i = 0;
        op_i = 6'h0; aluout_i = 32'h0; rdata2_i = 32'h0; except_i = 8'h0;
        bus.data_addr_ok = 0; bus.data_data_ok = 0; bus.data_rdata = 32'h0;
    endtask

    task automatic set_load(input logic [5:0] op, input logic [31:0] addr);
        memen_i = 1; rmem_i = 1; wmem_i = 0; op_i = op; aluout_i = addr;
    endtask

    // Load accepted on first cycle, data returned on the next.
    task automatic quick_load(input string tag, input logic [5:0] op, input logic [31:0] addr,
                              input logic [31:0] word, input logic [31:0] exp);
        set_load(op, addr);
        bus.data_addr_ok = 1;
        settle();
        check_eq({tag, "_req"}, 32'(bus.data_req), 32'd1);
        tick();
        bus.data_addr_ok = 0; bus.data_data_ok = 1; bus.data_rdata = word;
        settle();
        check_eq({tag, "_rdata"}, rdata_o, exp);
        check_eq({tag, "_stall"}, 32'(stall_o), 32'd0);
        tick();
        clear_inputs();
    endtask

    initial begin
        checks = 0; errors = 0;
        clear_inputs();
        rst_ni = 0;
        repeat (2) tick();
        settle();
        check_eq("rst_req", 32'(bus.data_req), 32'd0);
        check_eq("rst_stall", 32'(stall_o), 32'd0);
        check_eq("rst_rdata", rdata_o, 32'h0);
        check_eq("rst_except", 32'(except_o), 32'h0);
        tick();
        rst_ni = 1;

        // LW 0x100: addr_ok immediately, data_ok in the fourth cycle.
        set_load(OP_LW, 32'h100);
        stall_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            bus.data_addr_ok = (i == 0);
            bus.data_data_ok = (i == 3);
            bus.data_rdata   = 32'h80FF7F01;
            settle();
            if (i == 0) begin
                check_eq("lw_size", 32'(bus.data_size), 32'd2);
                check_eq("lw_addr", bus.data_addr, 32'h100);
                check_eq("lw_wstrb", 32'(bus.data_wstrb), 32'h0);
            end
            if (stall_o) stall_cnt++;
            if (i == 3) check_eq("lw_rdata", rdata_o, 32'h80FF7F01);
            tick();
        end
        check_eq("lw_stall_cycles", stall_cnt, 32'd3);
        clear_inputs();
        settle();
        check_eq("idle_rdata", rdata_o, 32'h0);
        tick();

        quick_load("lb",  OP_LB,  32'h103, 32'h80FF7F01, 32'hFFFFFF80);
        quick_load("lbu", OP_LBU, 32'h103, 32'h80FF7F01, 32'h00000080);
        quick_load("lh",  OP_LH,  32'h102, 32'h80FF7F01, 32'hFFFF80FF);
        quick_load("lhu", OP_LHU, 32'h100, 32'h80FF7F01, 32'h00007F01);

        // SH 0x202 store formatting.
        memen_i = 1; wmem_i = 1; op_i = OP_SH; aluout_i = 32'h202; rdata2_i = 32'h1234ABCD;
        bus.data_addr_ok = 1;
        settle();
        check_eq("sh_wdata", bus.data_wdata, 32'hABCDABCD);
        check_eq("sh_wstrb", 32'(bus.data_wstrb), 32'hC);
        check_eq("sh_size", 32'(bus.data_size), 32'd1);
        check_eq("sh_wr", 32'(bus.data_wr), 32'd1);
        tick();
        bus.data_addr_ok = 0; bus.data_data_ok = 1;
        settle();
        check_eq("sh_done_stall", 32'(stall_o), 32'd0);
        tick();
        clear_inputs();

        // SB 0x201 (accepted, completes the same way).
        memen_i = 1; wmem_i = 1; op_i = OP_SB; aluout_i = 32'h201; rdata2_i = 32'h1234ABCD;
        bus.data_addr_ok = 1;
        settle();
        check_eq("sb_wdata", bus.data_wdata, 32'hCDCDCDCD);
        check_eq("sb_wstrb", 32'(bus.data_wstrb), 32'h2);
        tick();
        bus.data_addr_ok = 0; bus.data_data_ok = 1;
        tick();
        clear_inputs();

        // Misaligned accesses raise address errors and issue nothing.
        set_load(OP_LW, 32'h101);
        settle();
        check_eq("adel_req", 32'(bus.data_req), 32'd0);
        check_eq("adel_except", 32'(except_o), 32'h10);
        check_eq("adel_stall", 32'(stall_o), 32'd0);
        tick();
        clear_inputs();
        memen_i = 1; wmem_i = 1; op_i = OP_SW; aluout_i = 32'h102;
        settle();
        check_eq("ades_except", 32'(except_o), 32'h20);
        check_eq("ades_req", 32'(bus.data_req), 32'd0);
        tick();
        clear_inputs();
        set_load(OP_LW, 32'h100); except_i = 8'h01;
        settle();
        check_eq("exc_in_req", 32'(bus.data_req), 32'd0);
        check_eq("exc_in_pass", 32'(except_o), 32'h01);
        tick();
        clear_inputs();

        // REQ state holds, then a flush withdraws the request.
        set_load(OP_LW, 32'h180);
        tick();
        settle();
        check_eq("reqst_req", 32'(bus.data_req), 32'd1);
        check_eq("reqst_stall", 32'(stall_o), 32'd1);
        tick();
        flush_i = 1;
        settle();
        check_eq("reqst_flush_req", 32'(bus.data_req), 32'd0);
        tick();
        clear_inputs();
        settle();
        check_eq("reqst_idle_stall", 32'(stall_o), 32'd0);
        tick();

        // Flush in WAIT -> CANCEL; next LW waits for the stale data_ok.
        set_load(OP_LW, 32'h100);
        bus.data_addr_ok = 1;
        tick();
        bus.data_addr_ok = 0; flush_i = 1;
        tick();
        flush_i = 0; set_load(OP_LW, 32'h300);
        settle();
        check_eq("cancel_req0", 32'(bus.data_req), 32'd0);
        check_eq("cancel_stall0", 32'(stall_o), 32'd1);
        tick();
        bus.data_data_ok = 1; bus.data_rdata = 32'hDEADBEEF;
        settle();
        check_eq("cancel_rdata", rdata_o, 32'h0);
        check_eq("cancel_req1", 32'(bus.data_req), 32'd0);
        check_eq("cancel_stall1", 32'(stall_o), 32'd1);
        tick();
        bus.data_data_ok = 0; bus.data_addr_ok = 1;
        settle();
        check_eq("after_cancel_req", 32'(bus.data_req), 32'd1);
        check_eq("after_cancel_addr", bus.data_addr, 32'h300);
        tick();
        bus.data_addr_ok = 0; bus.data_data_ok = 1; bus.data_rdata = 32'h11223344;
        settle();
        check_eq("after_cancel_rdata", rdata_o, 32'h11223344);
        tick();
        clear_inputs();

        // data_ok while stalled -> DONE holds the result.
        set_load(OP_LW, 32'h400);
        bus.data_addr_ok = 1;
        tick();
        bus.data_addr_ok = 0; bus.data_data_ok = 1; bus.data_rdata = 32'hCAFEF00D; stall_i = 1;
        settle();
        check_eq("done_first", rdata_o, 32'hCAFEF00D);
        tick();
        bus.data_data_ok = 0; bus.data_rdata = 32'h0;
        for (int i = 0; i < 2; i++) begin
            settle();
            check_eq("done_hold", rdata_o, 32'hCAFEF00D);
            check_eq("done_noreq", 32'(bus.data_req), 32'd0);
            tick();
        end
        stall_i = 0;
        settle();
        check_eq("done_release", rdata_o, 32'hCAFEF00D);
        tick();
        clear_inputs();
        settle();
        check_eq("done_exit", rdata_o, 32'h0);
        tick();

        // Reset mid-transaction, then a late data_ok is ignored.
        set_load(OP_LW, 32'h500);
        bus.data_addr_ok = 1;
        tick();
        bus.data_addr_ok = 0;
        rst_ni = 0;
        #1;
        check_eq("midrst_req", 32'(bus.data_req), 32'd0);
        check_eq("midrst_stall", 32'(stall_o), 32'd0);
        clear_inputs();
        tick();
        rst_ni = 1;
        bus.data_data_ok = 1; bus.data_rdata = 32'h55555555;
        settle();
        check_eq("late_ok_rdata", rdata_o, 32'h0);
        check_eq("late_ok_stall", 32'(stall_o), 32'd0);
        tick();
        clear_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
